expr_pipe: RTL and testbench
============================

# expr_pipe

Parametrised, pipelined successor to the combinational `top` expression evaluators. It evaluates a fixed per-stage arithmetic mix over STAGES registered stages, selected by a per-item mode bit. Valid/ready handshakes sit on both sides, and bubbles collapse under backpressure. It sits between an input producer and an output consumer in the generated-design flow, giving the same input_data/output_data shape with real sequential behaviour.

## Interface
- IN_W, default 3: width of input_data.
- OUT_W, default 20: width of output_data. Must be ≤ ACC_W.
- ACC_W, default 32: internal temp width. All stage arithmetic is modulo 2^ACC_W.
- STAGES, default 4, minimum 1: number of registered compute stages, which is also the latency.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input_data and in_mode are valid.
- in_ready  output  1  the block can accept an item this cycle.
- input_data  input  IN_W  operand.
- in_mode  input  1  0 = mul-add mix, 1 = shift-xor mix.
- out_valid  output  1  output_data is valid.
- out_ready  input  1  consumer accepts.
- output_data  output  OUT_W  result.
- checksum_data  output  OUT_W  running XOR of delivered results (see Configuration).

## Operation
- Transfer happens when valid && ready on the same rising edge, on either side.
- Entry value: t0 = zero-extend(input_data) to ACC_W. The mode bit travels with the item through every stage.
- Stage k, for k = 1..STAGES:
  - mode 0: t_k = t_{k-1}*5 + k.
  - mode 1: t_k = (t_{k-1} ^ (t_{k-1} << 2)) + k.
  - k is an ACC_W-bit constant. Every result wraps mod 2^ACC_W.
- output_data = t_STAGES[OUT_W-1:0], registered.
- Each stage holds {valid, mode, t}. Per-stage ready_k = !v_k || ready_{k+1}, with ready_{STAGES+1} = out_ready.
  - in_ready = ready_1. This is a combinational chain from out_ready.
  - A stage loads from its predecessor when ready_k. Its valid becomes v_{k-1}, with v_0 = in_valid.
- Consequences of the ready chain:
  - Bubbles are squeezed out.
  - A full pipeline with out_ready = 0 holds every stage unchanged.
  - in_ready = 0 only when all stages are valid and out_ready = 0.
- out_valid = v_STAGES. output_data must stay stable while out_valid && !out_ready.
- Items exit in acceptance order. No item is dropped or duplicated.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the integrator) gives:
  - all v_k = 0, all t_k = 0, all modes = 0;
  - out_valid = 0, output_data = 0, checksum_data = 0;
  - in_ready = 1 combinationally once rst_n = 1.
- Latency: an item accepted on edge N produces out_valid = 1 after edge N+STAGES-1. It is visible for the full cycle before edge N+STAGES, assuming no stall.
- Throughput: one item per cycle while out_ready = 1.
- Simultaneous delivery and acceptance while full and out_ready = 1: both complete, and occupancy is unchanged.
- Reset asserted mid-operation discards all in-flight items immediately. No partial result is delivered afterwards.
- in_mode and input_data are ignored when in_valid = 0. Values at the output with out_valid = 0 are don't-care, but stage registers hold.

## Configuration
- EXPR_PIPE_CHECKSUM_EN defined:
  - checksum_data <= checksum_data ^ output_data on every output handshake edge;
  - reset value 0;
  - updates occur only on handshake edges.
- EXPR_PIPE_CHECKSUM_EN undefined: checksum_data is tied to 0 and no checksum register is built. All other behaviour is identical.

## Test plan
All scenarios use default parameters.
- Reset, then single items with out_ready = 1:
  - input_data 3, mode 0 -> output_data 2069 (0x00815), 4 cycles after acceptance.
  - input_data 0, mode 0 -> 194.
  - input_data 7, mode 0 -> 4569.
- input_data 3, mode 1 -> 1389. Intermediate values are 16, 82, 285.
- Back-to-back stream 0..7 alternating mode, out_ready = 1 -> in_ready stays 1. Eight results appear on consecutive cycles in order and match the model.
- Stream with out_ready = 0 for 10 cycles:
  - in_ready falls after exactly 4 accepts;
  - output_data is stable while stalled;
  - on release, all items arrive in order with none lost.
- Random in_valid/out_ready (≥ 10k items, all modes, input 0..7) -> scoreboard match. With EXPR_PIPE_CHECKSUM_EN, checksum_data equals the model XOR of delivered outputs. Without the macro, checksum_data stays 0.
- Assert rst_n low with 3 items in flight -> out_valid = 0 and output_data = 0 immediately. After release, no stale item appears, and the next item 3 (mode 0) yields 2069.

Source files
------------

// File: rtl/expr_pipe.sv
// expr_pipe: pipelined arithmetic expression evaluator.
//
// Each accepted item is carried through STAGES registered compute stages
// together with its mode bit. Stage k applies either a mul-add step
// (t*5 + k) or a shift-xor step ((t ^ (t << 2)) + k), modulo 2^ACC_W.
// Valid/ready handshakes are used on both sides. Each stage's ready looks
// only at the stages downstream of it, so bubbles are squeezed out under
// backpressure.
//
// Optional feature: define EXPR_PIPE_CHECKSUM_EN to build a running XOR
// of every delivered result on checksum_data. Without the macro,
// checksum_data is tied to zero.
//
// Ports:
//   clk           - sole clock, rising edge
//   rst_n         - asynchronous active-low reset
//   in_valid      - input_data / in_mode are valid
//   in_ready      - block accepts an item this cycle (combinational from out_ready)
//   input_data    - operand, zero-extended to ACC_W on entry
//   in_mode       - 0 = mul-add mix, 1 = shift-xor mix
//   out_valid     - output_data is valid
//   out_ready     - consumer accepts
//   output_data   - low OUT_W bits of the final stage
//   checksum_data - running XOR of delivered results (0 when feature disabled)
module expr_pipe #(
    parameter int unsigned IN_W   = 3,
    parameter int unsigned OUT_W  = 20,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  input_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] output_data,
    output logic [OUT_W-1:0] checksum_data
);

    // Per-stage state: valid, mode and accumulator.
    logic [STAGES:1] v_q;
    logic            m_q [1:STAGES];
    logic [ACC_W-1:0] t_q [1:STAGES];

    // Per-stage ready and the values presented by each stage's predecessor.
    logic [STAGES:1] rdy;
    logic [STAGES:1] pv;
    logic            pm [1:STAGES];
    logic [ACC_W-1:0] pt [1:STAGES];

    function automatic logic [ACC_W-1:0] stage_op(
        input logic [ACC_W-1:0] x,
        input logic             mode,
        input int unsigned      k
    );
        logic [ACC_W-1:0] kc;
        kc = ACC_W'(k);
        if (mode)
            return (x ^ (x << 2)) + kc;
        else
            return (x * ACC_W'(5)) + kc;
    endfunction

    // ready_k = !v_k || ready_{k+1}, unrolled: a stage is blocked only when it
    // and every stage after it are occupied and the consumer is stalling.
    always_comb begin
        logic full;
        full = 1'b1;
        rdy  = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            full             = full & v_q[STAGES - i];
            rdy[STAGES - i]  = !full || out_ready;
        end
    end

    always_comb begin
        pv    = '0;
        pv[1] = in_valid;
        pm[1] = in_mode;
        pt[1] = ACC_W'(input_data);
        for (int unsigned k = 2; k <= STAGES; k++) begin
            pv[k] = v_q[k-1];
            pm[k] = m_q[k-1];
            pt[k] = t_q[k-1];
        end
    end

    // Payload only loads when a real item moves in; bubbles leave the
    // registers untouched so stale values simply sit behind a cleared valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int unsigned k = 1; k <= STAGES; k++) begin
                m_q[k] <= 1'b0;
                t_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 1; k <= STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= pv[k];
                    if (pv[k]) begin
                        m_q[k] <= pm[k];
                        t_q[k] <= stage_op(pt[k], pm[k], k);
                    end
                end
            end
        end
    end

    assign in_ready    = rdy[1];
    assign out_valid   = v_q[STAGES];
    assign output_data = t_q[STAGES][OUT_W-1:0];

`ifdef EXPR_PIPE_CHECKSUM_EN
    logic [OUT_W-1:0] cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cs_q <= '0;
        else if (out_valid && out_ready)
            cs_q <= cs_q ^ output_data;
    end

    assign checksum_data = cs_q;
`else
    assign checksum_data = '0;
`endif

endmodule

// File: tb/tb_expr_pipe.sv
module tb_expr_pipe;

    localparam int IN_W   = 3;
    localparam int OUT_W  = 20;
    localparam int ACC_W  = 32;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  input_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] output_data;
    logic [OUT_W-1:0] checksum_data;

    int checks = 0;
    int errors = 0;

    logic [OUT_W-1:0] sb_q [$];
    logic [OUT_W-1:0] exp_cs = '0;
    logic [OUT_W-1:0] mon_exp;

    expr_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ACC_W (ACC_W),
        .STAGES(STAGES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .input_data   (input_data),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .output_data  (output_data),
        .checksum_data(checksum_data)
    );

    always #5 clk = ~clk;

    // Reference model of the four-stage computation, 32-bit wrapping.
    function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] x, input logic m);
        logic [31:0] t;
        t = 32'(x);
        for (int k = 1; k <= 4; k++) begin
            if (m) t = (t ^ (t << 2)) + 32'(k);
            else   t = t * 32'd5 + 32'(k);
        end
        return t[OUT_W-1:0];
    endfunction

    // Scoreboard: push on input handshake, pop/compare on output handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got output %0d, required no item outstanding", output_data);
                end else begin
                    mon_exp = sb_q.pop_front();
                    exp_cs  = exp_cs ^ mon_exp;
                    if (output_data !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_data: got %0d, required %0d", output_data, mon_exp);
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1)
                sb_q.push_back(model(input_data, in_mode));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int n = 0; n < 200 && sb_q.size() != 0; n++) tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d items outstanding, required 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_mode    = 1'b0;
        input_data = '0;
        out_ready  = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        checks++;
        if (output_data !== '0) begin
            errors++; $display("FAIL reset_output_data: got %0d, required 0", output_data);
        end
        checks++;
        if (checksum_data !== '0) begin
            errors++; $display("FAIL reset_checksum: got %0d, required 0", checksum_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_single(input logic [IN_W-1:0] x, input logic m,
                               input logic [OUT_W-1:0] expv, input string name);
        logic acc;
        logic found;
        int   lat;
        tick();
        out_ready  = 1'b1;
        input_data = x;
        in_mode    = m;
        in_valid   = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++; $display("FAIL %s_accept: got no acceptance in 50 cycles, required accept", name);
        end
        lat   = 0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || lat != STAGES) begin
            errors++; $display("FAIL %s_latency: got %0d (found=%b), required %0d", name, lat, found, STAGES);
        end
        checks++;
        if (output_data !== expv) begin
            errors++; $display("FAIL %s_value: got %0d, required %0d", name, output_data, expv);
        end
        drain(name);
    endtask

    task automatic test_back_to_back;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            input_data = IN_W'(i);
            in_mode    = i[0];
            in_valid   = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_in_ready[%0d]: got %b, required 1", i, in_ready);
            end
            checks++;
            if (out_valid !== (i >= 4)) begin
                errors++; $display("FAIL b2b_out_valid[%0d]: got %b, required %b", i, out_valid, (i >= 4));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (j < 4)) begin
                errors++; $display("FAIL b2b_tail_valid[%0d]: got %b, required %b", j, out_valid, (j < 4));
            end
            @(posedge clk);
            #1;
        end
        drain("b2b");
    endtask

    task automatic test_stall;
        int               idx;
        int               accepts;
        logic             acc;
        logic             have_held;
        logic [OUT_W-1:0] held;
        tick();
        out_ready  = 1'b0;
        idx        = 0;
        input_data = '0;
        in_mode    = 1'b0;
        in_valid   = 1'b1;
        accepts    = 0;
        have_held  = 1'b0;
        held       = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) accepts++;
            if (out_valid === 1'b1) begin
                if (have_held) begin
                    checks++;
                    if (output_data !== held) begin
                        errors++; $display("FAIL stall_stable[%0d]: got %0d, required %0d", c, output_data, held);
                    end
                end else begin
                    held      = output_data;
                    have_held = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                input_data = idx[IN_W-1:0];
                in_mode    = idx[0];
            end
        end
        checks++;
        if (accepts != STAGES) begin
            errors++; $display("FAIL stall_accepts: got %0d, required %0d", accepts, STAGES);
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_full: got in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
        end
        drain("stall");
    endtask

    task automatic test_random;
        int               sent;
        logic             acc;
        logic [OUT_W-1:0] cs_req;
        sent = 0;
        tick();
        for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
            in_valid   = ($urandom_range(0, 99) < 70);
            input_data = IN_W'($urandom_range(0, 7));
            in_mode    = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 99) < 65);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        checks++;
        if (sent != 10000) begin
            errors++; $display("FAIL random_sent: got %0d, required 10000", sent);
        end
        drain("random");
`ifdef EXPR_PIPE_CHECKSUM_EN
        cs_req = exp_cs;
`else
        cs_req = '0;
`endif
        checks++;
        if (checksum_data !== cs_req) begin
            errors++; $display("FAIL random_checksum: got %0d, required %0d", checksum_data, cs_req);
        end
    endtask

    task automatic test_reset_mid;
        logic [OUT_W-1:0] cs_req;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            input_data = IN_W'(i + 1);
            in_mode    = 1'b0;
            in_valid   = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        exp_cs = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_out_valid: got %b, required 0", out_valid);
        end
        checks++;
        if (output_data !== '0) begin
            errors++; $display("FAIL midreset_output_data: got %0d, required 0", output_data);
        end
        checks++;
        if (checksum_data !== '0) begin
            errors++; $display("FAIL midreset_checksum: got %0d, required 0", checksum_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_stale[%0d]: got out_valid %b, required 0", c, out_valid);
            end
        end
        test_single(3'd3, 1'b0, 20'd2069, "post_reset");
`ifdef EXPR_PIPE_CHECKSUM_EN
        cs_req = 20'd2069;
`else
        cs_req = '0;
`endif
        checks++;
        if (checksum_data !== cs_req) begin
            errors++; $display("FAIL post_reset_checksum: got %0d, required %0d", checksum_data, cs_req);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single(3'd3, 1'b0, 20'd2069, "single_3_m0");
        test_single(3'd0, 1'b0, 20'd194,  "single_0_m0");
        test_single(3'd7, 1'b0, 20'd4569, "single_7_m0");
        test_single(3'd3, 1'b1, 20'd1389, "single_3_m1");
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
